// File: rtl/dport_axi_pkg.sv
// Shared constants for the DisplayPort-side AXI3 read responder.
// Burst/response encodings and the R-channel beat payload layout.
package dport_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Beat payload packed as {rdata, rid, rresp, rlast}
    localparam int R_DATA_W    = 64;
    localparam int R_ID_W      = 6;
    localparam int R_PAYLOAD_W = R_DATA_W + R_ID_W + 2 + 1;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_BURST,
        RD_DONE
    } rd_state_t;

endpackage

// File: rtl/axi_skid2.sv
// Two-entry valid/ready buffer; the head entry drives the output and is held
// stable until it is popped.
module axi_skid2
    import dport_axi_pkg::*;
#(
    parameter int W = R_PAYLOAD_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [1:0]   count;
    logic         pop;

    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign occupancy = count;

    // The writer never pushes into a full buffer unless it is also popping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (in_valid) begin
                        head  <= in_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (in_valid && pop) begin
                        head <= in_data;
                    end else if (in_valid) begin
                        tail  <= in_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head <= tail;
                        if (in_valid) begin
                            tail <= in_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_resp.sv
// AXI3 read responder (64-bit) in front of a synchronous-read memory port.
// One burst in flight; beats are returned through a 2-entry skid buffer.
module axi_rd_resp
    import dport_axi_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] SIZE   = 32'h0010_0000,
    parameter int                MEMA_W = 17
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [5:0]        arid,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [63:0]       rdata,
    output logic [5:0]        rid,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic [MEMA_W-1:0] memaddr,
    output logic              memrd,
    input  logic [63:0]       memdata
);

    rd_state_t state, next_state;

    logic [ADDR_W-1:0] addr_q;
    logic [5:0]        id_q;
    logic [3:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [3:0]        beat_q;
    logic [1:0]        err_q;

    logic              pend_valid;
    logic              pend_last;
    logic [1:0]        pend_resp;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] ar_offset;
    logic              in_range;
    logic [1:0]        beat_resp;
    logic [1:0]        ar_err;
    logic              ar_hs;
    logic              pop;
    logic [1:0]        occupancy;
    logic [2:0]        slots_used;
    logic              issue;
    logic [R_PAYLOAD_W-1:0] push_data;
    logic [R_PAYLOAD_W-1:0] head_data;

    assign offset    = addr_q - BASE;
    assign ar_offset = araddr - BASE;
    assign in_range  = (offset < SIZE);
    assign ar_hs     = arvalid && arready;
    assign pop       = rvalid && rready;

    // Once a beat goes bad the rest of the burst stays bad.
    assign beat_resp = (err_q != RESP_OKAY) ? err_q :
                       (in_range ? RESP_OKAY : RESP_DECERR);

    always_comb begin
        ar_err = RESP_OKAY;
        if (arsize > 3'd3 || arburst == BURST_WRAP || arburst == 2'd3) begin
            ar_err = RESP_SLVERR;
        end else if (!(ar_offset < SIZE)) begin
            ar_err = RESP_DECERR;
        end
    end

    // A same-cycle pop frees a slot, which is what sustains one beat per cycle.
    assign slots_used = {1'b0, occupancy} + {2'b00, pend_valid} - {2'b00, pop};
    assign issue      = (state == RD_BURST) && (slots_used < 3'd2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= RD_IDLE;
            arready <= 1'b0;
        end else begin
            state   <= next_state;
            arready <= (next_state == RD_IDLE);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RD_IDLE:  if (ar_hs) next_state = RD_BURST;
            RD_BURST: if (issue && beat_q == len_q) next_state = RD_DONE;
            RD_DONE:  if (pop && rlast) next_state = RD_IDLE;
            default:  next_state = RD_IDLE;
        endcase
    end

    always_comb begin
        memrd   = issue && (beat_resp == RESP_OKAY);
        memaddr = offset[MEMA_W+2:3];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '0;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            err_q      <= RESP_OKAY;
            pend_valid <= 1'b0;
            pend_last  <= 1'b0;
            pend_resp  <= RESP_OKAY;
        end else begin
            pend_valid <= issue;
            if (ar_hs) begin
                addr_q  <= araddr;
                id_q    <= arid;
                len_q   <= arlen;
                size_q  <= arsize;
                burst_q <= arburst;
                beat_q  <= '0;
                err_q   <= ar_err;
            end else if (issue) begin
                beat_q    <= beat_q + 4'd1;
                err_q     <= beat_resp;
                pend_last <= (beat_q == len_q);
                pend_resp <= beat_resp;
                if (burst_q == BURST_INCR) begin
                    addr_q <= addr_q + (ADDR_W'(1) << size_q);
                end
            end
        end
    end

    assign push_data = {(pend_resp == RESP_OKAY) ? memdata : 64'h0,
                        id_q, pend_resp, pend_last};

    axi_skid2 #(.W(R_PAYLOAD_W)) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (pend_valid),
        .in_data   (push_data),
        .out_valid (rvalid),
        .out_data  (head_data),
        .out_ready (rready),
        .occupancy (occupancy)
    );

    assign {rdata, rid, rresp, rlast} = head_data;

endmodule
